zmc_banked: RTL and testbench

Parametrised Z80 memory-window controller for the sound subsystem: maps the Z80's upper 32 KiB (8000h–FFFFh) onto a larger M-ROM through up to four banked windows of 2/4/8/16 KiB, and passes the lower 32 KiB through unchanged. Window registers are loaded by Z80 port reads: SDA_L selects the window and SDA_U carries the bank value. The loaded bank takes effect on the rising edge of nSDRD0. It sits between the Z80 address bus and the M-ROM address generator. It adds a configurable window count and output width, a bank-change pulse, and an optional deferred commit that keeps MA stable across an in-flight memory read.

---
 rtl/zmc_banked_if.sv | 22 ++
 rtl/zmc_banked.sv | 118 +++++++++++
 tb/tb_zmc_banked.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/zmc_banked_if.sv
// Z80-side bus bundle for zmc_banked: bank-port/memory strobes, address, mapped MA and status.
interface zmc_banked_if #(
  parameter int unsigned MA_W = 8
);
  logic            nSDRD0;
  logic            nSDMRD;
  logic [1:0]      SDA_L;
  logic [7:0]      SDA_U;
  logic [MA_W-1:0] MA;
  logic            BANK_CHG;
  logic            PEND;

  modport master (
    output nSDRD0, nSDMRD, SDA_L, SDA_U,
    input  MA, BANK_CHG, PEND
  );

  modport slave (
    input  nSDRD0, nSDMRD, SDA_L, SDA_U,
    output MA, BANK_CHG, PEND
  );
endinterface

// File: rtl/zmc_banked.sv
// Z80 upper-32K banked window controller onto M-ROM; lower 32K passes through.
// Optional deferred commit across in-flight memory reads: define ZMC_DEFER_EN.
module zmc_banked #(
  parameter int unsigned MA_W    = 8,
  parameter int unsigned NUM_WIN = 4
) (
  input  logic         CLK,
  input  logic         nRESET,
  zmc_banked_if.slave  bus
);
  localparam int unsigned NW = 4;
  localparam logic [NW-1:0][MA_W-1:0] RST_WIN = {
    MA_W'(8'h02), MA_W'(8'h06), MA_W'(8'h0E), MA_W'(8'h1E)
  };

  logic [NW-1:0][MA_W-1:0] win_q, win_d;
  logic                    sdrd_q;
  logic                    bank_chg_q, bank_chg_d;
  logic                    ev_c;
  logic                    impl_c;
  logic [MA_W-1:0]         wval_c;
  logic [MA_W-1:0]         ma_c;
  logic [7:0]              a;

  assign a      = bus.SDA_U;
  assign ev_c   = bus.nSDRD0 & ~sdrd_q;
  assign impl_c = 32'(bus.SDA_L) < NUM_WIN;
  // Window k holds MA_W-k bits; wider-than-8 registers get zero upper bits.
  assign wval_c = MA_W'(bus.SDA_U) & ({MA_W{1'b1}} >> bus.SDA_L);

`ifdef ZMC_DEFER_EN
  logic [NW-1:0]           pv_q, pv_d;
  logic [NW-1:0][MA_W-1:0] pval_q, pval_d;
  logic                    pend_q, pend_d;

  assign pend_d = |pv_d;
`else
  logic unused_mrd;
  assign unused_mrd = bus.nSDMRD;
`endif

  // Next-state: pending commit first, then a fresh event overrides its own window.
  always_comb begin
    win_d      = win_q;
    bank_chg_d = 1'b0;
`ifdef ZMC_DEFER_EN
    pv_d   = pv_q;
    pval_d = pval_q;
    if (bus.nSDMRD && (|pv_q)) begin
      for (int k = 0; k < NW; k++) begin
        if (pv_q[k]) win_d[k] = pval_q[k];
      end
      pv_d       = '0;
      bank_chg_d = 1'b1;
    end
    if (ev_c && impl_c) begin
      if (!bus.nSDMRD) begin
        pv_d[bus.SDA_L]   = 1'b1;
        pval_d[bus.SDA_L] = wval_c;
      end else begin
        win_d[bus.SDA_L] = wval_c;
        bank_chg_d       = 1'b1;
      end
    end
`else
    if (ev_c && impl_c) begin
      win_d[bus.SDA_L] = wval_c;
      bank_chg_d       = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      win_q      <= RST_WIN;
      sdrd_q     <= 1'b1;
      bank_chg_q <= 1'b0;
`ifdef ZMC_DEFER_EN
      pv_q       <= '0;
      pval_q     <= '0;
      pend_q     <= 1'b0;
`endif
    end else begin
      win_q      <= win_d;
      sdrd_q     <= bus.nSDRD0;
      bank_chg_q <= bank_chg_d;
`ifdef ZMC_DEFER_EN
      pv_q       <= pv_d;
      pval_q     <= pval_d;
      pend_q     <= pend_d;
`endif
    end
  end

  // Address decode W0 > W1 > W2 > W3; unimplemented windows fall back to identity.
  always_comb begin
    ma_c = MA_W'(a[7:3]);
    if (a[7]) begin
      if (a[6:4] == 3'b111) begin
        ma_c = win_q[0];
      end else if (a[6:4] == 3'b110) begin
        if (NUM_WIN > 1) ma_c = (win_q[1] << 1) | MA_W'(a[3]);
      end else if (a[6:5] == 2'b10) begin
        if (NUM_WIN > 2) ma_c = (win_q[2] << 2) | MA_W'(a[4:3]);
      end else begin
        if (NUM_WIN > 3) ma_c = (win_q[3] << 3) | MA_W'(a[5:3]);
      end
    end
  end

  assign bus.MA       = ma_c;
  assign bus.BANK_CHG = bank_chg_q;
`ifdef ZMC_DEFER_EN
  assign bus.PEND     = pend_q;
`else
  assign bus.PEND     = 1'b0;
`endif
endmodule

// File: tb/tb_zmc_banked.sv
// Scoreboard bench for zmc_banked: two instances (4 and 2 windows) against an address-arithmetic model.
module tb_zmc_banked;
  localparam int unsigned MA_W = 8;
  localparam int unsigned NW0  = 4;
  localparam int unsigned NW1  = 2;

  typedef struct packed {
    logic [MA_W-1:0] ma0;
    logic [MA_W-1:0] ma1;
    logic            chg0;
    logic            chg1;
    logic            pend0;
    logic            pend1;
  } exp_t;

  logic CLK;
  logic nRESET;
  int   vectors;
  int   miscompares;
  exp_t q[$];

  int unsigned m_win [2][4];
  int unsigned m_pval[2][4];
  bit          m_pv  [2][4];
  bit          m_prev[2];

  zmc_banked_if #(.MA_W(MA_W)) bus ();
  zmc_banked_if #(.MA_W(MA_W)) bus2 ();

  assign bus2.nSDRD0 = bus.nSDRD0;
  assign bus2.nSDMRD = bus.nSDMRD;
  assign bus2.SDA_L  = bus.SDA_L;
  assign bus2.SDA_U  = bus.SDA_U;

  zmc_banked #(.MA_W(MA_W), .NUM_WIN(NW0)) dut (
    .CLK(CLK), .nRESET(nRESET), .bus(bus.slave)
  );
  zmc_banked #(.MA_W(MA_W), .NUM_WIN(NW1)) dut2 (
    .CLK(CLK), .nRESET(nRESET), .bus(bus2.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int unsigned nwin(int i);
    return (i == 0) ? NW0 : NW1;
  endfunction

  // ROM bank for a CPU address: region picks the window, low 2K-block bits fill the rest.
  function automatic int unsigned model_ma(int i, logic [7:0] u);
    int unsigned addr, blk, k, ma;
    addr = 32'(u) << 8;
    blk  = addr / 2048;
    if (addr < 32'h8000) return blk;
    if (addr >= 32'hF000)      begin k = 0; ma = m_win[i][0];                end
    else if (addr >= 32'hE000) begin k = 1; ma = m_win[i][1] * 2 + blk % 2; end
    else if (addr >= 32'hC000) begin k = 2; ma = m_win[i][2] * 4 + blk % 4; end
    else                       begin k = 3; ma = m_win[i][3] * 8 + blk % 8; end
    if (k >= nwin(i)) return blk;
    return ma % (1 << MA_W);
  endfunction

  function automatic bit model_pend(int i);
    bit p = 1'b0;
    for (int k = 0; k < 4; k++) p = p | m_pv[i][k];
    return p;
  endfunction

  task automatic model_reset(int i);
    m_win[i][0] = 32'h1E; m_win[i][1] = 32'h0E; m_win[i][2] = 32'h06; m_win[i][3] = 32'h02;
    for (int k = 0; k < 4; k++) begin m_pv[i][k] = 1'b0; m_pval[i][k] = 0; end
    m_prev[i] = 1'b1;
  endtask

  task automatic model_edge(input int i, input bit rst, input bit sdrd, input bit mrd,
                            input logic [1:0] l, input logic [7:0] u, output bit chg);
    bit ev;
    int unsigned val;
    chg = 1'b0;
    if (!rst) begin model_reset(i); return; end
    ev = sdrd && !m_prev[i];
    m_prev[i] = sdrd;
`ifdef ZMC_DEFER_EN
    if (mrd) begin
      for (int k = 0; k < 4; k++) begin
        if (m_pv[i][k]) begin m_win[i][k] = m_pval[i][k]; m_pv[i][k] = 1'b0; chg = 1'b1; end
      end
    end
`endif
    if (ev && 32'(l) < nwin(i)) begin
      val = 32'(u) % (1 << (MA_W - 32'(l)));
`ifdef ZMC_DEFER_EN
      if (!mrd) begin m_pv[i][l] = 1'b1; m_pval[i][l] = val; end
      else begin m_win[i][l] = val; chg = 1'b1; end
`else
      m_win[i][l] = val;
      chg = 1'b1;
`endif
    end
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue what the next rising edge must produce.
  task automatic cycle(input bit rst, input bit sdrd, input bit mrd,
                       input logic [1:0] l, input logic [7:0] u);
    exp_t e;
    bit c0, c1;
    @(negedge CLK);
    nRESET     = rst;
    bus.nSDRD0 = sdrd;
    bus.nSDMRD = mrd;
    bus.SDA_L  = l;
    bus.SDA_U  = u;
    model_edge(0, rst, sdrd, mrd, l, u, c0);
    model_edge(1, rst, sdrd, mrd, l, u, c1);
    e.ma0   = MA_W'(model_ma(0, u));
    e.ma1   = MA_W'(model_ma(1, u));
    e.chg0  = c0;
    e.chg1  = c1;
    e.pend0 = model_pend(0);
    e.pend1 = model_pend(1);
    q.push_back(e);
  endtask

  task automatic load(input bit mrd, input logic [1:0] l, input logic [7:0] u);
    cycle(1'b1, 1'b0, mrd, l, u);
    cycle(1'b1, 1'b1, mrd, l, u);
  endtask

  // Monitor: every rising edge with an outstanding expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ma_nw4",   32'(bus.MA),        32'(e.ma0));
        chk("ma_nw2",   32'(bus2.MA),       32'(e.ma1));
        chk("chg_nw4",  32'(bus.BANK_CHG),  32'(e.chg0));
        chk("chg_nw2",  32'(bus2.BANK_CHG), 32'(e.chg1));
        chk("pend_nw4", 32'(bus.PEND),      32'(e.pend0));
        chk("pend_nw2", 32'(bus2.PEND),     32'(e.pend1));
      end
    end
  end

  initial begin
    bit sdrd;
    vectors = 0;
    miscompares = 0;
    nRESET = 1'b0;
    bus.nSDRD0 = 1'b1; bus.nSDMRD = 1'b1; bus.SDA_L = 2'd0; bus.SDA_U = 8'h00;
    model_reset(0);
    model_reset(1);
    repeat (2) cycle(1'b0, 1'b1, 1'b1, 2'd0, 8'h00);

    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'hF0); #1 chk("rst_f0", 32'(bus.MA), 32'h1E);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'hE8); #1 chk("rst_e8", 32'(bus.MA), 32'h1D);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'hC0); #1 chk("rst_c0", 32'(bus.MA), 32'h18);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'h80); #1 chk("rst_80", 32'(bus.MA), 32'h10);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'h48); #1 chk("rst_48", 32'(bus.MA), 32'h09);

    load(1'b1, 2'd2, 8'h2A);
    cycle(1'b1, 1'b1, 1'b1, 2'd2, 8'hD8);
    #1 chk("w2_load", 32'(bus.MA), 32'hAB);
    chk("w2_chg", 32'(bus.BANK_CHG), 32'h1);

    load(1'b1, 2'd3, 8'hFF);
    cycle(1'b1, 1'b1, 1'b1, 2'd3, 8'hB8);
    #1 chk("w3_trunc", 32'(bus.MA), 32'hFF);
    chk("w3_unimpl", 32'(bus2.MA), 32'h17);
    chk("w3_unimpl_chg", 32'(bus2.BANK_CHG), 32'h0);

    cycle(1'b1, 1'b0, 1'b1, 2'd2, 8'hD8);
    cycle(1'b0, 1'b0, 1'b1, 2'd2, 8'hD8);
    #1 chk("async_rst", 32'(bus.MA), 32'h1B);
    cycle(1'b1, 1'b1, 1'b1, 2'd2, 8'h55);
    cycle(1'b1, 1'b1, 1'b1, 2'd2, 8'hD8);
    #1 chk("rst_release_ma", 32'(bus.MA), 32'h1B);
    chk("rst_release_chg", 32'(bus.BANK_CHG), 32'h0);

`ifdef ZMC_DEFER_EN
    load(1'b0, 2'd0, 8'h33);
    load(1'b0, 2'd1, 8'h05);
    load(1'b0, 2'd0, 8'h44);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'hF0);
    #1 chk("defer_hold_ma", 32'(bus.MA), 32'h1E);
    chk("defer_pend", 32'(bus.PEND), 32'h1);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'hF0);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'hE8);
    #1 chk("commit_w1", 32'(bus.MA), 32'h0B);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'hF0);
    #1 chk("commit_w0", 32'(bus.MA), 32'h44);
    chk("commit_pend", 32'(bus.PEND), 32'h0);
    load(1'b0, 2'd0, 8'h11);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'h22);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'h22);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'hF0);
    #1 chk("simul_override", 32'(bus.MA), 32'h22);
`endif

    sdrd = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      sdrd = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 299) != 0), sdrd, ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom));
    end
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drain", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
